// File: rtl/streamer_block_rx.sv
// Receive-side block reassembler: buffers rx_streamer words and releases a block
// to the valid/ready user port only once its last word has arrived intact.
module streamer_block_rx #(
    parameter int g_data_width      = 64,
    parameter int g_max_block_words = 16,
    parameter int g_buffer_words    = 64
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_n_i,
    input  logic [g_data_width-1:0] snk_data_i,
    input  logic                    snk_valid_i,
    input  logic                    snk_first_i,
    input  logic                    snk_last_i,
    input  logic                    snk_lost_i,
    output logic                    snk_dreq_o,
    output logic [g_data_width-1:0] blk_data_o,
    output logic                    blk_valid_o,
    output logic                    blk_first_o,
    output logic                    blk_last_o,
    input  logic                    blk_ready_i,
    output logic [7:0]              blk_count_o,
    output logic [15:0]             stat_dropped_o,
    input  logic                    stat_clear_i
);

    localparam int AW = $clog2(g_buffer_words);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(g_max_block_words + 1);

    localparam logic [PW:0]   c_buf_words = (PW+1)'(g_buffer_words);
    localparam logic [PW:0]   c_two       = (PW+1)'(2);
    localparam logic [LW-1:0] c_max_len   = LW'(g_max_block_words);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISCARD} wr_state_t;

    wr_state_t         state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     len_q, len_d;
    logic              dreq_q, dreq_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              rd_vld_q, rd_vld_d;
    logic              out_vld_q, out_vld_d;
    logic [g_data_width-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              first_pend_q, first_pend_d;

    logic [g_data_width:0] mem [g_buffer_words];
    logic [g_data_width:0] ram_rd_q;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic              commit;
    logic              drop;
    logic              start_blk;
    logic              xfer;
    logic              xfer_last;
    logic              load_out;
    logic              rd_issue;
    logic [PW-1:0]     used_w, used_c;
    logic [PW:0]       free_w, free_c;

    // free_c is the space seen after rewinding an aborted block to commit_ptr
    assign used_w = wr_ptr_q - rd_ptr_q;
    assign used_c = commit_ptr_q - rd_ptr_q;
    assign free_w = c_buf_words - {1'b0, used_w};
    assign free_c = c_buf_words - {1'b0, used_c};

    // Write side
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        wr_en        = 1'b0;
        wr_addr      = wr_ptr_q[AW-1:0];
        commit       = 1'b0;
        drop         = 1'b0;
        start_blk    = 1'b0;

        case (state_q)
            S_IDLE: begin
                start_blk = snk_valid_i;
            end
            S_COLLECT: begin
                if (snk_lost_i) begin
                    drop     = 1'b1;
                    wr_ptr_d = commit_ptr_q;
                    state_d  = S_DISCARD;
                    // a word arriving with the lost pulse is judged as in DISCARD
                    if (snk_valid_i) begin
                        if (snk_first_i) begin
                            start_blk = 1'b1;
                        end else if (snk_last_i) begin
                            state_d = S_IDLE;
                        end
                    end
                end else if (snk_valid_i) begin
                    if (snk_first_i) begin
                        drop      = 1'b1;
                        wr_ptr_d  = commit_ptr_q;
                        start_blk = 1'b1;
                    end else if (len_q == c_max_len || free_w == '0) begin
                        // an aborting word that is also last already ends the block
                        drop     = 1'b1;
                        wr_ptr_d = commit_ptr_q;
                        state_d  = snk_last_i ? S_IDLE : S_DISCARD;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        len_d    = len_q + LW'(1);
                        if (snk_last_i) begin
                            commit       = 1'b1;
                            commit_ptr_d = wr_ptr_q + PW'(1);
                            state_d      = S_IDLE;
                        end
                    end
                end
            end
            S_DISCARD: begin
                if (snk_valid_i) begin
                    if (snk_first_i) begin
                        start_blk = 1'b1;
                    end else if (snk_last_i) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // block start always writes at commit_ptr so it also covers the rewind case
        if (start_blk) begin
            if (!snk_first_i || free_c == '0) begin
                drop    = 1'b1;
                state_d = snk_last_i ? S_IDLE : S_DISCARD;
            end else begin
                wr_en    = 1'b1;
                wr_addr  = commit_ptr_q[AW-1:0];
                wr_ptr_d = commit_ptr_q + PW'(1);
                len_d    = LW'(1);
                if (snk_last_i) begin
                    commit       = 1'b1;
                    commit_ptr_d = commit_ptr_q + PW'(1);
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
        end
    end

    // Read side: RAM read register feeding a first-word-fall-through output register
    always_comb begin
        xfer      = out_vld_q & blk_ready_i;
        xfer_last = xfer & out_last_q;
        load_out  = rd_vld_q & (~out_vld_q | xfer);
        rd_issue  = (rd_ptr_q != commit_ptr_q) & (~rd_vld_q | load_out);

        rd_ptr_d     = rd_issue ? rd_ptr_q + PW'(1) : rd_ptr_q;
        rd_vld_d     = rd_issue | (rd_vld_q & ~load_out);
        out_vld_d    = load_out | (out_vld_q & ~xfer);
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        if (load_out) begin
            out_data_d = ram_rd_q[g_data_width-1:0];
            out_last_d = ram_rd_q[g_data_width];
        end
        first_pend_d = xfer ? out_last_q : first_pend_q;
    end

    // Status
    always_comb begin
        dreq_d = (free_w >= c_two);
        cnt_d  = cnt_q + {7'b0, commit} - {7'b0, xfer_last};
        drop_cnt_d = drop_cnt_q;
        if (stat_clear_i) begin
            drop_cnt_d = '0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (wr_en) begin
            mem[wr_addr] <= {snk_last_i, snk_data_i};
        end
        if (rd_issue) begin
            ram_rd_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            dreq_q       <= 1'b0;
            cnt_q        <= '0;
            drop_cnt_q   <= '0;
            rd_vld_q     <= 1'b0;
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            first_pend_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            dreq_q       <= dreq_d;
            cnt_q        <= cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            rd_vld_q     <= rd_vld_d;
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            first_pend_q <= first_pend_d;
        end
    end

    assign snk_dreq_o     = dreq_q;
    assign blk_data_o     = out_data_q;
    assign blk_valid_o    = out_vld_q;
    assign blk_first_o    = out_vld_q & first_pend_q;
    assign blk_last_o     = out_vld_q & out_last_q;
    assign blk_count_o    = cnt_q;
    assign stat_dropped_o = drop_cnt_q;

endmodule

// File: tb/tb_streamer_block_rx.sv
// Bench for streamer_block_rx: directed vector table, fill/drain, reset and
// randomized blocks checked against a block-level queue model.
module tb_streamer_block_rx;

    localparam int DW   = 64;
    localparam int MAXW = 16;
    localparam int BUFW = 64;
    localparam int M_IDLE = 0;
    localparam int M_COLL = 1;
    localparam int M_DISC = 2;

    logic          clk_sys_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [DW-1:0] snk_data_i = '0;
    logic          snk_valid_i = 1'b0;
    logic          snk_first_i = 1'b0;
    logic          snk_last_i = 1'b0;
    logic          snk_lost_i = 1'b0;
    logic          snk_dreq_o;
    logic [DW-1:0] blk_data_o;
    logic          blk_valid_o;
    logic          blk_first_o;
    logic          blk_last_o;
    logic          blk_ready_i = 1'b0;
    logic [7:0]    blk_count_o;
    logic [15:0]   stat_dropped_o;
    logic          stat_clear_i = 1'b0;

    always #5 clk_sys_i = ~clk_sys_i;

    streamer_block_rx #(
        .g_data_width(DW), .g_max_block_words(MAXW), .g_buffer_words(BUFW)
    ) dut (
        .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i),
        .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i), .snk_first_i(snk_first_i),
        .snk_last_i(snk_last_i), .snk_lost_i(snk_lost_i), .snk_dreq_o(snk_dreq_o),
        .blk_data_o(blk_data_o), .blk_valid_o(blk_valid_o), .blk_first_o(blk_first_o),
        .blk_last_o(blk_last_o), .blk_ready_i(blk_ready_i), .blk_count_o(blk_count_o),
        .stat_dropped_o(stat_dropped_o), .stat_clear_i(stat_clear_i)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Block-level reference model
    typedef struct { logic [63:0] data; bit first; bit last; } word_t;
    word_t       exp_q[$];
    logic [63:0] pq[$];
    logic [63:0] out_log[$];
    int mode = M_IDLE;
    int model_cnt = 0;
    int model_drop = 0;
    int drop_inc = 0;
    int rdy_pct = 100;

    task automatic m_commit();
        word_t w;
        for (int i = 0; i < pq.size(); i++) begin
            w.data  = pq[i];
            w.first = (i == 0);
            w.last  = (i == pq.size() - 1);
            exp_q.push_back(w);
        end
        pq.delete();
        model_cnt++;
        mode = M_IDLE;
    endtask

    task automatic m_start(bit f, bit l, logic [63:0] d);
        if (!f) begin
            drop_inc++;
            mode = l ? M_IDLE : M_DISC;
        end else begin
            pq.delete();
            pq.push_back(d);
            if (l) m_commit();
            else mode = M_COLL;
        end
    endtask

    task automatic m_step(bit v, bit f, bit l, bit lo, bit clr, logic [63:0] d);
        drop_inc = 0;
        if (lo && mode == M_COLL) begin
            drop_inc++;
            pq.delete();
            mode = M_DISC;
        end
        if (v) begin
            if (mode == M_COLL) begin
                if (f) begin
                    drop_inc++;
                    pq.delete();
                    m_start(f, l, d);
                end else if (pq.size() == MAXW) begin
                    drop_inc++;
                    pq.delete();
                    mode = l ? M_IDLE : M_DISC;
                end else begin
                    pq.push_back(d);
                    if (l) m_commit();
                end
            end else if (mode == M_DISC) begin
                if (f) m_start(f, l, d);
                else if (l) mode = M_IDLE;
            end else begin
                m_start(f, l, d);
            end
        end
        if (clr) model_drop = 0;
        else if (model_drop + drop_inc > 65535) model_drop = 65535;
        else model_drop = model_drop + drop_inc;
    endtask

    // One clock of stimulus; inputs change 1 ns after the active edge
    task automatic send(bit v, bit f, bit l, bit lo, bit clr, logic [63:0] d);
        snk_valid_i  = v;
        snk_first_i  = f;
        snk_last_i   = l;
        snk_lost_i   = lo;
        stat_clear_i = clr;
        snk_data_i   = d;
        blk_ready_i  = ($urandom_range(0, 99) < rdy_pct);
        @(posedge clk_sys_i);
        m_step(v, f, l, lo, clr, d);
        #1;
    endtask

    task automatic send_word(bit f, bit l, logic [63:0] d);
        int n;
        n = 0;
        while (!snk_dreq_o && n < 200) begin
            send(0, 0, 0, 0, 0, '0);
            n++;
        end
        if (n >= 200) chk("dreq_wait", 64'(snk_dreq_o), 1);
        send(1, f, l, 0, 0, d);
    endtask

    task automatic drain(int maxc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || blk_valid_o) && n < maxc) begin
            send(0, 0, 0, 0, 0, '0);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        chk("drain_count", blk_count_o, 0);
    endtask

    // Output monitor, sampled on the falling edge
    bit          holding = 0;
    logic [63:0] hold_data;
    bit          hold_last;
    word_t       mon_w;

    always @(negedge clk_sys_i) begin
        if (!rst_n_i) begin
            holding = 0;
        end else begin
            chk("blk_count", blk_count_o, model_cnt);
            chk("stat_dropped", stat_dropped_o, model_drop);
            if (blk_valid_o) begin
                if (holding) begin
                    chk("hold_data", blk_data_o, hold_data);
                    chk("hold_last", blk_last_o, hold_last);
                end
                if (blk_ready_i) begin
                    holding = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", blk_valid_o, 0);
                    end else begin
                        mon_w = exp_q.pop_front();
                        chk("out_data", blk_data_o, mon_w.data);
                        chk("out_first", blk_first_o, mon_w.first);
                        chk("out_last", blk_last_o, mon_w.last);
                        if (mon_w.last) model_cnt--;
                    end
                    out_log.push_back(blk_data_o);
                    $display("xfer data=%h first=%0b last=%0b", blk_data_o, blk_first_o, blk_last_o);
                end else begin
                    holding   = 1;
                    hold_data = blk_data_o;
                    hold_last = blk_last_o;
                end
            end else if (holding) begin
                chk("hold_valid", blk_valid_o, 1);
                holding = 0;
            end
        end
    end

    // Directed vector table
    typedef struct { bit v; bit f; bit l; bit lo; bit clr; logic [63:0] d; int exp_drop; } vec_t;
    vec_t tv[$];
    logic [63:0] tab_out [13] = '{0, 1, 2, 3, 4, 5, 'h12, 'h13, 'h40, 'h41, 'h60, 'h61, 'h73};

    function automatic vec_t mk(bit v, bit f, bit l, bit lo, bit clr, logic [63:0] d, int ed);
        vec_t r;
        r.v = v; r.f = f; r.l = l; r.lo = lo; r.clr = clr; r.d = d; r.exp_drop = ed;
        return r;
    endfunction

    task automatic table_phase();
        tv.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 0, 1, 0));
        tv.push_back(mk(1, 0, 1, 0, 0, 2, 0));
        tv.push_back(mk(1, 1, 0, 0, 0, 3, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 4, 0));
        tv.push_back(mk(1, 0, 1, 0, 0, 5, 0));
        tv.push_back(mk(1, 1, 0, 0, 0, 'h10, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 'h11, 0));
        tv.push_back(mk(1, 1, 0, 0, 0, 'h12, 1));
        tv.push_back(mk(1, 0, 1, 0, 0, 'h13, 1));
        tv.push_back(mk(1, 1, 0, 0, 0, 'h20, 1));
        for (int k = 'h21; k <= 'h2F; k++) tv.push_back(mk(1, 0, 0, 0, 0, k, 1));
        tv.push_back(mk(1, 0, 1, 0, 0, 'h30, 2));
        tv.push_back(mk(1, 1, 0, 0, 0, 'h40, 2));
        tv.push_back(mk(1, 0, 1, 0, 0, 'h41, 2));
        tv.push_back(mk(1, 1, 0, 0, 0, 'h50, 2));
        tv.push_back(mk(1, 0, 0, 0, 0, 'h51, 2));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 3));
        tv.push_back(mk(1, 0, 0, 0, 0, 'h52, 3));
        tv.push_back(mk(1, 0, 1, 0, 0, 'h53, 3));
        tv.push_back(mk(1, 1, 0, 0, 0, 'h60, 3));
        tv.push_back(mk(1, 0, 1, 0, 0, 'h61, 3));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 1, 'h70, 0));
        tv.push_back(mk(1, 0, 1, 0, 0, 'h71, 0));
        tv.push_back(mk(1, 0, 1, 0, 0, 'h72, 1));
        tv.push_back(mk(1, 1, 1, 0, 0, 'h73, 1));

        rdy_pct = 100;
        out_log.delete();
        for (int i = 0; i < tv.size(); i++) begin
            send(tv[i].v, tv[i].f, tv[i].l, tv[i].lo, tv[i].clr, tv[i].d);
            chk($sformatf("tv%0d_drop", i), stat_dropped_o, tv[i].exp_drop);
        end
        drain(100);
        chk("tab_words", out_log.size(), 13);
        for (int i = 0; i < 13 && i < out_log.size(); i++)
            chk($sformatf("tab_out%0d", i), out_log[i], tab_out[i]);
    endtask

    task automatic fill_phase();
        rdy_pct = 0;
        out_log.delete();
        for (int b = 0; b < 16; b++)
            for (int w = 0; w < 4; w++)
                send_word(w == 0, w == 3, 64'h1000 + 64'(b * 4 + w));
        repeat (4) send(0, 0, 0, 0, 0, '0);
        chk("fill_count", blk_count_o, 16);
        chk("fill_valid", blk_valid_o, 1);
        chk("fill_first", blk_first_o, 1);
        chk("fill_data", blk_data_o, 64'h1000);
        rdy_pct = 100;
        drain(200);
        chk("fill_words", out_log.size(), 64);
        for (int i = 0; i < 64 && i < out_log.size(); i++)
            chk($sformatf("fill_out%0d", i), out_log[i], 64'h1000 + 64'(i));
        chk("fill_dreq", snk_dreq_o, 1);
    endtask

    task automatic random_phase();
        int len;
        int kind;
        bit f;
        bit l;
        rdy_pct = 75;
        for (int b = 0; b < 60; b++) begin
            len  = $urandom_range(1, 18);
            kind = $urandom_range(0, 9);
            for (int w = 0; w < len; w++) begin
                f = (w == 0) && (kind != 0);
                l = (w == len - 1) && (kind != 2);
                if (kind == 1 && w > 0 && w == len / 2) send(0, 0, 0, 1, 0, '0);
                if ($urandom_range(0, 4) == 0) send(0, 0, 0, 0, 0, '0);
                send_word(f, l, {$urandom, $urandom});
            end
            if ($urandom_range(0, 9) == 0) send(0, 0, 0, 1, 0, '0);
        end
        rdy_pct = 100;
        drain(400);
    endtask

    task automatic reset_phase();
        rdy_pct = 0;
        send_word(1, 0, 'hA0);
        send_word(0, 1, 'hA1);
        send_word(1, 0, 'hB0);
        send_word(0, 1, 'hB1);
        send_word(1, 0, 'hC0);
        repeat (3) send(0, 0, 0, 0, 0, '0);
        chk("pre_rst_count", blk_count_o, 2);
        rst_n_i = 1'b0;
        #1;
        chk("rst2_valid", blk_valid_o, 0);
        chk("rst2_first", blk_first_o, 0);
        chk("rst2_last", blk_last_o, 0);
        chk("rst2_data", blk_data_o, 0);
        chk("rst2_count", blk_count_o, 0);
        chk("rst2_dreq", snk_dreq_o, 0);
        exp_q.delete();
        pq.delete();
        mode = M_IDLE;
        model_cnt = 0;
        model_drop = 0;
        repeat (2) @(posedge clk_sys_i);
        #1;
        rst_n_i = 1'b1;
        rdy_pct = 100;
        send(0, 0, 0, 0, 0, '0);
        chk("rst2_dreq_rise", snk_dreq_o, 1);
        send_word(1, 1, 'hD0);
        chk("lat_n", blk_valid_o, 0);
        send(0, 0, 0, 0, 0, '0);
        chk("lat_n1", blk_valid_o, 0);
        send(0, 0, 0, 0, 0, '0);
        chk("lat_n2", blk_valid_o, 1);
        chk("lat_first", blk_first_o, 1);
        chk("lat_data", blk_data_o, 'hD0);
        drain(50);
    endtask

    initial begin
        repeat (3) @(posedge clk_sys_i);
        #1;
        chk("rst_valid", blk_valid_o, 0);
        chk("rst_first", blk_first_o, 0);
        chk("rst_last", blk_last_o, 0);
        chk("rst_data", blk_data_o, 0);
        chk("rst_count", blk_count_o, 0);
        chk("rst_dropped", stat_dropped_o, 0);
        chk("rst_dreq", snk_dreq_o, 0);
        rst_n_i = 1'b1;
        #1;
        chk("dreq_before_edge", snk_dreq_o, 0);
        send(0, 0, 0, 0, 0, '0);
        chk("dreq_after_edge", snk_dreq_o, 1);

        table_phase();
        fill_phase();
        random_phase();
        reset_phase();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
